// File: rtl/umi_pkg.sv
// Shared constants for the UMI arbiter: arbitration mode encodings and the
// chaos-pushback LFSR seed/taps.
package umi_pkg;

    localparam logic UMI_ARB_RR    = 1'b0;
    localparam logic UMI_ARB_FIXED = 1'b1;

    // Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10
    localparam logic [15:0] UMI_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] UMI_LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/umi_arbiter_pick.sv
// Combinational N-way picker: fixed priority from index 0, or round-robin
// search starting at the pointer and wrapping modulo N.
module umi_arbiter_pick
    import umi_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic          mode_i,
    input  logic [CW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [CW-1:0] idx_o
);

    int   start;
    int   cand;
    logic found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        start   = (mode_i == UMI_ARB_FIXED) ? 0 : int'(ptr_i);
        for (int k = 0; k < N; k++) begin
            cand = (start + k) % N;
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = CW'(cand);
            end
        end
    end

endmodule

// File: rtl/umi_arbiter.sv
// N-to-1 UMI arbiter with a registered single-entry output stage.
// Define UMI_ARBITER_CHAOS_EN to build the LFSR-driven random pushback.
module umi_arbiter
    import umi_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int UW = 256,
    localparam int CW = $clog2(N)
) (
    input  logic            umi_clk,
    input  logic            umi_reset,
    input  logic            mode,
    input  logic [N-1:0]    mask,
    input  logic            chaosmode,
    input  logic [N-1:0]    umi_in_valid,
    input  logic [N*UW-1:0] umi_in_packet,
    output logic [N-1:0]    umi_in_ready,
    output logic            umi_out_valid,
    output logic [UW-1:0]   umi_out_packet,
    output logic [CW-1:0]   umi_out_srcid,
    input  logic            umi_out_ready
);

    // Handshake: a beat moves when valid & ready are both high at a rising
    // edge; ready is derived from grant and output-register space only.
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [CW-1:0] pick_idx;
    logic          accept;
    logic          chaos_stall;
    logic          xfer;

    logic          out_valid_q, out_valid_d;
    logic [UW-1:0] out_packet_q, out_packet_d;
    logic [CW-1:0] out_srcid_q, out_srcid_d;
    logic [CW-1:0] ptr_q, ptr_d;

    assign req = umi_in_valid & ~mask;

    umi_arbiter_pick #(.N(N), .CW(CW)) u_pick (
        .req_i   (req),
        .mode_i  (mode),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (pick_idx)
    );

`ifdef UMI_ARBITER_CHAOS_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d      = {lfsr_q[14:0], ^(lfsr_q & UMI_LFSR_TAPS)};
    assign chaos_stall = chaosmode & lfsr_q[0];

    always_ff @(posedge umi_clk) begin
        if (umi_reset) lfsr_q <= UMI_LFSR_SEED;
        else           lfsr_q <= lfsr_d;
    end
`else
    logic unused_chaosmode;
    assign unused_chaosmode = chaosmode;
    assign chaos_stall      = 1'b0;
`endif

    assign accept       = (~out_valid_q | umi_out_ready) & ~chaos_stall;
    assign umi_in_ready = grant & {N{accept & ~umi_reset}};
    assign xfer         = |umi_in_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_packet_d = out_packet_q;
        out_srcid_d  = out_srcid_q;
        ptr_d        = ptr_q;
        if (accept) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_packet_d = umi_in_packet[pick_idx*UW +: UW];
                out_srcid_d  = pick_idx;
                ptr_d        = (pick_idx == CW'(N-1)) ? '0 : pick_idx + 1'b1;
            end
        end else if (out_valid_q && umi_out_ready) begin
            // Chaos stall: the current beat still leaves, nothing replaces it
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge umi_clk) begin
        if (umi_reset) begin
            out_valid_q  <= 1'b0;
            out_packet_q <= '0;
            out_srcid_q  <= '0;
            ptr_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_packet_q <= out_packet_d;
            out_srcid_q  <= out_srcid_d;
            ptr_q        <= ptr_d;
        end
    end

    assign umi_out_valid  = out_valid_q;
    assign umi_out_packet = out_packet_q;
    assign umi_out_srcid  = out_srcid_q;

endmodule

// File: tb/tb_umi_arbiter.sv
// Self-checking bench for umi_arbiter: directed vector table, hand sequences,
// randomized traffic against a behavioural model and a packet scoreboard.
module tb_umi_arbiter;
    localparam int N  = 4;
    localparam int UW = 64;
    localparam int CW = 2;

    logic            clk;
    logic            umi_reset;
    logic            mode;
    logic [N-1:0]    mask;
    logic            chaosmode;
    logic [N-1:0]    umi_in_valid;
    logic [N*UW-1:0] umi_in_packet;
    logic [N-1:0]    umi_in_ready;
    logic            umi_out_valid;
    logic [UW-1:0]   umi_out_packet;
    logic [CW-1:0]   umi_out_srcid;
    logic            umi_out_ready;

    umi_arbiter #(.N(N), .UW(UW)) dut (
        .umi_clk        (clk),
        .umi_reset      (umi_reset),
        .mode           (mode),
        .mask           (mask),
        .chaosmode      (chaosmode),
        .umi_in_valid   (umi_in_valid),
        .umi_in_packet  (umi_in_packet),
        .umi_in_ready   (umi_in_ready),
        .umi_out_valid  (umi_out_valid),
        .umi_out_packet (umi_out_packet),
        .umi_out_srcid  (umi_out_srcid),
        .umi_out_ready  (umi_out_ready)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters, model state, scoreboard ----------------
    int vectors     = 0;
    int miscompares = 0;
    int delivered   = 0;
    int chaos_stalls = 0;

    logic          m_valid;
    logic [UW-1:0] m_pkt;
    int            m_src;
    int            m_ptr;
    logic [15:0]   m_lfsr;

    logic [CW+UW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [UW-1:0] act, input logic [UW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive at negedge, check, advance the model.
    task automatic step(input logic rst, input logic [N-1:0] v, input logic [N-1:0] m,
                        input logic md, input logic ordy, input logic chaos);
        logic [UW-1:0] pkt[N];
        logic          acc;
        int            winner;
        int            start;
        logic [N-1:0]  exp_rdy;
        logic [CW+UW-1:0] head;
        @(negedge clk);
        umi_reset     = rst;
        umi_in_valid  = v;
        mask          = m;
        mode          = md;
        umi_out_ready = ordy;
        chaosmode     = chaos;
        for (int i = 0; i < N; i++) begin
            pkt[i] = {$urandom, $urandom};
            umi_in_packet[i*UW +: UW] = pkt[i];
        end
        #1;
        chk("out_valid", UW'(umi_out_valid), UW'(m_valid));
        chk("out_packet", umi_out_packet, m_pkt);
        chk("out_srcid", UW'(umi_out_srcid), UW'(m_src));

        // Eligible requester found by scanning from the pointer (or 0) around the ring
        acc = !m_valid || ordy;
`ifdef UMI_ARBITER_CHAOS_EN
        if (chaos && m_lfsr[0]) begin
            if (acc) chaos_stalls++;
            acc = 1'b0;
        end
`endif
        winner = -1;
        start  = md ? 0 : m_ptr;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (start + k) % N;
            if (winner < 0 && v[idx] && !m[idx]) winner = idx;
        end
        exp_rdy = '0;
        if (!rst && acc && winner >= 0) exp_rdy[winner] = 1'b1;
        chk("in_ready", UW'(umi_in_ready), UW'(exp_rdy));

        if (umi_out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                head = exp_q.pop_front();
                chk("sb_srcid", UW'(umi_out_srcid), UW'(head[CW+UW-1:UW]));
                chk("sb_packet", umi_out_packet, head[UW-1:0]);
                delivered++;
            end
        end

        if (rst) begin
            exp_q.delete();
            m_valid = 1'b0; m_pkt = '0; m_src = 0; m_ptr = 0;
            m_lfsr  = 16'hACE1;
        end else begin
            if (acc) begin
                m_valid = (winner >= 0);
                if (winner >= 0) begin
                    m_pkt = pkt[winner];
                    m_src = winner;
                    m_ptr = (winner + 1) % N;
                    exp_q.push_back({CW'(winner), pkt[winner]});
                end
            end else if (m_valid && ordy) begin
                m_valid = 1'b0;
            end
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] m;
        logic         md;
        logic         ordy;
        logic [N-1:0] exp_rdy;
        logic         exp_ov;
        int           exp_src;
    } vec_t;

    vec_t tbl[24];

    initial begin
        umi_reset = 1'b1; mode = 1'b0; mask = '0; chaosmode = 1'b0;
        umi_in_valid = '0; umi_in_packet = '0; umi_out_ready = 1'b0;
        m_valid = 1'b0; m_pkt = '0; m_src = 0; m_ptr = 0; m_lfsr = 16'hACE1;

        // round-robin, all valid
        tbl[0]  = '{4'hF, 4'h0, 1'b0, 1'b1, 4'b0001, 1'b0, 0};
        tbl[1]  = '{4'hF, 4'h0, 1'b0, 1'b1, 4'b0010, 1'b1, 0};
        tbl[2]  = '{4'hF, 4'h0, 1'b0, 1'b1, 4'b0100, 1'b1, 1};
        tbl[3]  = '{4'hF, 4'h0, 1'b0, 1'b1, 4'b1000, 1'b1, 2};
        tbl[4]  = '{4'hF, 4'h0, 1'b0, 1'b1, 4'b0001, 1'b1, 3};
        // mask requester 2, then clear it
        tbl[5]  = '{4'hF, 4'h4, 1'b0, 1'b1, 4'b0010, 1'b1, 0};
        tbl[6]  = '{4'hF, 4'h4, 1'b0, 1'b1, 4'b1000, 1'b1, 1};
        tbl[7]  = '{4'hF, 4'h4, 1'b0, 1'b1, 4'b0001, 1'b1, 3};
        tbl[8]  = '{4'hF, 4'h4, 1'b0, 1'b1, 4'b0010, 1'b1, 0};
        tbl[9]  = '{4'hF, 4'h0, 1'b0, 1'b1, 4'b0100, 1'b1, 1};
        tbl[10] = '{4'hF, 4'h0, 1'b0, 1'b1, 4'b1000, 1'b1, 2};
        // fixed priority with requester 1 withdrawing
        tbl[11] = '{4'hA, 4'h0, 1'b1, 1'b1, 4'b0010, 1'b1, 3};
        tbl[12] = '{4'hA, 4'h0, 1'b1, 1'b1, 4'b0010, 1'b1, 1};
        tbl[13] = '{4'h8, 4'h0, 1'b1, 1'b1, 4'b1000, 1'b1, 1};
        tbl[14] = '{4'h0, 4'h0, 1'b1, 1'b1, 4'b0000, 1'b1, 3};
        tbl[15] = '{4'h0, 4'h0, 1'b1, 1'b1, 4'b0000, 1'b0, 3};
        // backpressure for five cycles
        tbl[16] = '{4'hF, 4'h0, 1'b0, 1'b1, 4'b0001, 1'b0, 3};
        for (int i = 17; i <= 21; i++) tbl[i] = '{4'hF, 4'h0, 1'b0, 1'b0, 4'b0000, 1'b1, 0};
        tbl[22] = '{4'hF, 4'h0, 1'b0, 1'b1, 4'b0010, 1'b1, 0};
        tbl[23] = '{4'hF, 4'h0, 1'b0, 1'b1, 4'b0100, 1'b1, 1};

        // reset held 3 cycles with all inputs valid
        for (int i = 0; i < 3; i++) step(1'b1, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            step(1'b0, tbl[i].v, tbl[i].m, tbl[i].md, tbl[i].ordy, 1'b0);
            chk($sformatf("tbl%0d_ready", i), UW'(umi_in_ready), UW'(tbl[i].exp_rdy));
            chk($sformatf("tbl%0d_ov", i), UW'(umi_out_valid), UW'(tbl[i].exp_ov));
            chk($sformatf("tbl%0d_src", i), UW'(umi_out_srcid), UW'(tbl[i].exp_src));
        end

        // reset mid-operation with a beat buffered and stalled
        step(1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("post_reset_ov", UW'(umi_out_valid), UW'(0));
        chk("post_reset_ready", UW'(umi_in_ready), UW'(4'b0001));

        // randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] rm;
            rm = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            step($urandom_range(0, 199) == 0, N'($urandom), rm, 1'($urandom),
                 $urandom_range(0, 3) != 0, 1'b0);
        end

`ifdef UMI_ARBITER_CHAOS_EN
        begin
            int start_cnt;
            int budget;
            start_cnt = delivered;
            budget    = 0;
            while (delivered - start_cnt < 1000 && budget < 20000) begin
                step(1'b0, N'($urandom), '0, 1'b0, $urandom_range(0, 7) != 0, 1'b1);
                budget++;
            end
            chk("chaos_delivered", UW'(delivered - start_cnt >= 1000), UW'(1));
            chk("chaos_stalls_seen", UW'(chaos_stalls > 0), UW'(1));
        end
`endif

        // drain and confirm nothing is left outstanding
        for (int c = 0; c < 4; c++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk("sb_empty", UW'(exp_q.size()), UW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
